// File: rtl/uart_word_rx.sv
// uart_word_rx: 16x-oversampled UART receiver that packs BYTES_PER_WORD bytes into a valid/ready word
module uart_word_rx #(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 115200,
    parameter int BYTES_PER_WORD = 2,
    parameter int PARITY         = 0,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                          CLOCK_50,
    input  logic                          arst_n,
    input  logic                          rx,
    output logic [8*BYTES_PER_WORD-1:0]   out_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int TW  = $clog2(DIV);
    localparam int BW  = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TO  = 16 * TIMEOUT_BITS;
    localparam int IW  = $clog2(TO + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic                        rx_m, rx_s;
    logic [TW-1:0]               tcnt;
    logic                        tick, mid, vote, exp_par, accept, complete, hs;
    logic [2:0]                  state;
    logic [3:0]                  smp;
    logic                        s7, s8, drop;
    logic [2:0]                  bit_idx;
    logic [7:0]                  data;
    logic [BW-1:0]               byte_idx;
    logic [8*BYTES_PER_WORD-1:0] shadow, word;
    logic [IW-1:0]               icnt;

    assign tick     = tcnt == TW'(DIV - 1);
    assign mid      = tick && smp == 4'd9;
    assign vote     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign exp_par  = PARITY == 1 ? ~^data : ^data;
    assign accept   = state == STOP && mid && vote && !drop;
    assign complete = accept && byte_idx == BW'(BYTES_PER_WORD - 1);
    assign hs       = word_valid & word_ready;

    // Shadow word with the byte just received dropped into its slot
    always_comb begin
        word = shadow;
        word[8*byte_idx +: 8] = data;
    end

    // Two-flop synchroniser for the asynchronous line
    always_ff @(posedge CLOCK_50) begin
        if (!arst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Free-running 16x sample tick divider
    always_ff @(posedge CLOCK_50) begin
        if (!arst_n) tcnt <= '0;
        else tcnt <= tick ? '0 : tcnt + TW'(1);
    end

    // Frame FSM: sample voting, parity/stop checks, byte assembly and idle timeout
    always_ff @(posedge CLOCK_50) begin
        if (!arst_n) begin
            state      <= IDLE;
            smp        <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            drop       <= 1'b0;
            bit_idx    <= '0;
            data       <= '0;
            byte_idx   <= '0;
            shadow     <= '0;
            icnt       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            icnt <= (state != IDLE || byte_idx == '0) ? '0 : icnt + IW'(tick);
            if (tick) begin
                smp <= smp + 4'd1;
                if (smp == 4'd7) s7 <= rx_s;
                if (smp == 4'd8) s8 <= rx_s;
                case (state)
                    IDLE: begin
                        smp <= '0;
                        if (!rx_s) state <= START;
                        if (byte_idx != '0 && icnt == IW'(TO - 1)) byte_idx <= '0;
                    end
                    START: begin
                        if (smp == 4'd9 && vote) state <= IDLE;
                        if (smp == 4'd15) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            drop    <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (smp == 4'd9) data <= {vote, data[7:1]};
                        if (smp == 4'd15) begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end
                    PAR: begin
                        if (smp == 4'd9 && vote != exp_par) begin
                            parity_err <= 1'b1;
                            drop       <= 1'b1;
                            byte_idx   <= '0;
                        end
                        if (smp == 4'd15) state <= STOP;
                    end
                    STOP: begin
                        if (smp == 4'd9) begin
                            state <= IDLE;
                            if (!vote) begin
                                frame_err <= 1'b1;
                                byte_idx  <= '0;
                            end else if (!drop) begin
                                shadow   <= word;
                                byte_idx <= complete ? '0 : byte_idx + BW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output word register with valid/ready handshake and overrun detection
    always_ff @(posedge CLOCK_50) begin
        if (!arst_n) begin
            out_data   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!word_valid || hs) begin
                    out_data   <= word;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (hs) begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule
